ex_mdu: RTL

//   Multi-cycle multiply/divide unit of the EX stage, beside the ALU. Holds the
//   HI/LO register pair. Executes mult/multu/div/divu with fixed latency and

---
 rtl/mdu_defs_pkg.sv | 25 ++
 rtl/ex_mdu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package mdu_defs;

    // Widths of the operand and op-code fields
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    // MDU operation codes carried from decode
    typedef enum logic [OP_W-1:0] {
        MDU_NONE = 3'd0,
        MULT     = 3'd1,
        MULTU    = 3'd2,
        DIV      = 3'd3,
        DIVU     = 3'd4,
        MTHI     = 3'd5,
        MTLO     = 3'd6
    } mdu_op_e;

    // Control FSM states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/ex_mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// Results are computed combinationally at issue and parked in pending
// registers; the FSM only models the fixed latency before they commit.
module ex_mdu
    import mdu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    mdu_state_e        state, state_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [DATA_W-1:0] pend_hi, pend_hi_next;
    logic [DATA_W-1:0] pend_lo, pend_lo_next;
    logic              pend_wr, pend_wr_next;
    logic [DATA_W-1:0] hi_next, lo_next;
    logic              busy_next;
    mdu_op_e           op_e;

    // Arithmetic datapath
    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;
    logic signed [DATA_W-1:0]   dividend_s, divisor_s, quot_s, rem_s;
    logic        [DATA_W-1:0]   divisor_u, quot_u, rem_u;
    logic                       div_zero, div_ovf;

    assign op_e = mdu_op_e'(op);

    // Full-width products and guarded quotients; the divisor is forced to 1
    // on divide-by-zero (result discarded) and on the single signed overflow
    // case, where A/1 yields exactly the wrapped quotient and zero remainder.
    always_comb begin
        prod_s     = $signed({{DATA_W{A[DATA_W-1]}}, A}) * $signed({{DATA_W{B[DATA_W-1]}}, B});
        prod_u     = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
        div_zero   = (B == '0);
        div_ovf    = (A == {1'b1, {(DATA_W-1){1'b0}}}) && (B == {DATA_W{1'b1}});
        dividend_s = $signed(A);
        divisor_s  = (div_zero || div_ovf) ? DATA_W'(signed'(1)) : $signed(B);
        divisor_u  = div_zero ? DATA_W'(1) : B;
        quot_s     = dividend_s / divisor_s;
        rem_s      = dividend_s % divisor_s;
        quot_u     = A / divisor_u;
        rem_u      = A % divisor_u;
    end

    // Next-state, pending-result and HI/LO update logic
    always_comb begin
        state_next   = state;
        count_next   = count;
        pend_hi_next = pend_hi;
        pend_lo_next = pend_lo;
        pend_wr_next = pend_wr;
        hi_next      = HI;
        lo_next      = LO;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op_e)
                        MULT: begin
                            pend_hi_next = prod_s[2*DATA_W-1:DATA_W];
                            pend_lo_next = prod_s[DATA_W-1:0];
                            pend_wr_next = 1'b1;
                            count_next   = CNT_W'(MULT_CYCLES - 1);
                            state_next   = BUSY;
                        end
                        MULTU: begin
                            pend_hi_next = prod_u[2*DATA_W-1:DATA_W];
                            pend_lo_next = prod_u[DATA_W-1:0];
                            pend_wr_next = 1'b1;
                            count_next   = CNT_W'(MULT_CYCLES - 1);
                            state_next   = BUSY;
                        end
                        DIV: begin
                            pend_hi_next = rem_s;
                            pend_lo_next = quot_s;
                            pend_wr_next = !div_zero;
                            count_next   = CNT_W'(DIV_CYCLES - 1);
                            state_next   = BUSY;
                        end
                        DIVU: begin
                            pend_hi_next = rem_u;
                            pend_lo_next = quot_u;
                            pend_wr_next = !div_zero;
                            count_next   = CNT_W'(DIV_CYCLES - 1);
                            state_next   = BUSY;
                        end
                        MTHI:    hi_next = A;
                        MTLO:    lo_next = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (count == '0) begin
                    if (pend_wr) begin
                        hi_next = pend_hi;
                        lo_next = pend_lo;
                    end
                    state_next = IDLE;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == BUSY);
    end

    // State, counter, pending results and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            pend_hi <= pend_hi_next;
            pend_lo <= pend_lo_next;
            pend_wr <= pend_wr_next;
            busy    <= busy_next;
            HI      <= hi_next;
            LO      <= lo_next;
        end
    end

endmodule
